date_preset_ctrl: RTL and testbench
===================================

// Module: date_preset_ctrl
// PURPOSE
//   Upstream stage of the calendar counter chain (year/month/day).
//   Lets the user load a start date using two push buttons (mode, inc).
//   Debounces and one-pulses both buttons, then steps through year -> month -> day edit states.
//   Edits BCD values with per-month/leap-year day limits and issues a 1-cycle load pulse to the counters.
// PARAMETERS
//   DEB_CYCLES    4    consecutive equal synchronized samples needed to accept a new button level
//   BLINK_CYCLES  8    clk cycles per half-period of the blink output
// PORTS
//   clk          in   1  system clock (the divided clock that drives the calendar counters)
//   rst          in   1  asynchronous, active-low reset
//   btn_mode     in   1  raw mode button, asynchronous
//   btn_inc      in   1  raw increment button, asynchronous
//   cur_y1,cur_y0,cur_m1,cur_m0,cur_d1,cur_d0  in 4 each  running BCD date from the counters
//   set_y1,set_y0,set_m1,set_m0,set_d1,set_d0  out 4 each registered BCD date being edited
//   load         out  1  1-cycle pulse: counters load set_* on this clk edge
//   editing      out  1  high in any EDIT_* state
//   field_sel    out  2  0 = none, 1 = year, 2 = month, 3 = day
//   blink        out  1  square wave for flashing the selected field; 0 when not editing
// BEHAVIOUR
// - Reset (rst = 0, asynchronous):
//   - State goes to RUN.
//   - set_* = 00-01-01 (year 00, month 01, day 01).
//   - load, editing, field_sel, blink = 0.
//   - Debounce counters and levels clear to 0.
//   - Reset mid-edit discards the edit; no load is issued.
// - Button conditioning (each button independently):
//   - 2-FF synchronizer feeds a debounce counter.
//   - The debounced level changes only after DEB_CYCLES consecutive synchronized samples differ from it.
//   - A 0->1 change of the debounced level yields mode_p / inc_p high for exactly 1 cycle.
//   - Bounce shorter than DEB_CYCLES produces no pulse.
// - FSM states: RUN, EDIT_Y, EDIT_M, EDIT_D, COMMIT.
//   - RUN: on mode_p, capture cur_* into set_* and go to EDIT_Y. inc_p is ignored.
//   - EDIT_Y: on mode_p go to EDIT_M. On inc_p, year += 1 in BCD; 99 wraps to 00.
//   - EDIT_M: on mode_p go to EDIT_D. On inc_p, month += 1; 12 wraps to 01.
//   - EDIT_D: on mode_p go to COMMIT. On inc_p, day += 1; max_day wraps to 01.
//   - COMMIT: load = 1 for this single cycle, set_* held; next state is RUN.
// - Simultaneous mode_p and inc_p: mode_p wins and the increment is dropped.
// - max_day:
//   - 31 for months 1, 3, 5, 7, 8, 10, 12.
//   - 30 for months 4, 6, 9, 11.
//   - February: 29 when year % 4 == 0 (00 counts as leap), else 28.
//   - Leap test uses BCD: (y1 even and y0 in {0,4,8}) or (y1 odd and y0 in {2,6}).
// - Day clamp: set_d is clamped to max_day on the cycle the FSM leaves EDIT_Y and on the cycle it leaves EDIT_M.
//   - Example: 31 with month 04 becomes 30.
//   - Example: 29 in February with year 01 becomes 28.
// - If the captured cur_* date is out of range, each field is forced into range on capture:
//   - month 00 or >12 becomes 01.
//   - day 00 becomes 01.
// - BCD digits never hold values above 9.
// - Outputs are all registered. load asserts exactly 1 cycle after the mode_p that ends EDIT_D.
// - blink: toggles every BLINK_CYCLES cycles while editing; forced to 0 and counter cleared in RUN/COMMIT.
// - field_sel: 1 in EDIT_Y, 2 in EDIT_M, 3 in EDIT_D, 0 otherwise.
// TESTING
// - Reset release, then cur = 17-03-15, press mode 4x with no inc -> COMMIT; load pulses once with set = 17-03-15; back in RUN.
// - EDIT_Y at 99, one inc -> set_y = 00; EDIT_M at 12, one inc -> set_m = 01; EDIT_D at 31 (month 01) -> 01.
// - Enter with cur = 16-01-31, set month to 02, then mode -> set_d = 29; repeat with year 17 -> set_d = 28.
// - Bounce btn_inc 0/1 with pulses of DEB_CYCLES-1 cycles, then hold 20 cycles -> exactly one increment.
// - mode_p and inc_p on the same cycle in EDIT_Y at 05 -> state EDIT_M, set_y stays 05.
// - Assert rst in EDIT_D with set = 20-06-30 -> set = 00-01-01, RUN, load never pulses, blink = 0.

Source files
------------

// File: rtl/date_preset_ctrl.sv
// Start-date editor for the calendar counter chain: debounced mode/inc buttons walk year -> month -> day.
// Outputs are registered; load is a single-cycle pulse one cycle after the mode press that ends day editing.
module date_preset_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int BLINK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_y1,
    input  logic [3:0] cur_y0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    input  logic [3:0] cur_d1,
    input  logic [3:0] cur_d0,
    output logic [3:0] set_y1,
    output logic [3:0] set_y0,
    output logic [3:0] set_m1,
    output logic [3:0] set_m0,
    output logic [3:0] set_d1,
    output logic [3:0] set_d0,
    output logic       load,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [2:0] {RUN, EDIT_Y, EDIT_M, EDIT_D, COMMIT} state_t;

    state_t          state, state_nx;
    logic [1:0]      sync1, sync2, level, pulse;
    logic [DW-1:0]   deb_cnt [2];
    logic [BW-1:0]   blink_cnt;
    logic [7:0]      set_y, set_m, set_d;
    logic [7:0]      y_nx, m_nx, d_nx, md;
    logic            mode_p, inc_p, edit_nx;

    // Bit 0 is the mode button, bit 1 the increment button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_inc, btn_mode};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] != level[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        level[i]   <= sync2[i];
                        pulse[i]   <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign mode_p = pulse[0];
    assign inc_p  = pulse[1];

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] max_day(input logic [7:0] m, input logic [7:0] y);
        logic leap;
        leap = y[4] ? (y[3:0] == 4'd2 || y[3:0] == 4'd6)
                    : (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8);
        case (m)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    assign md = max_day(set_m, set_y);

    always_comb begin
        state_nx = state;
        y_nx     = set_y;
        m_nx     = set_m;
        d_nx     = set_d;
        case (state)
            RUN: if (mode_p) begin
                // Captured fields are forced back into legal BCD ranges.
                y_nx[7:4] = (cur_y1 > 4'd9) ? 4'd0 : cur_y1;
                y_nx[3:0] = (cur_y0 > 4'd9) ? 4'd0 : cur_y0;
                m_nx = {cur_m1, cur_m0};
                if (cur_m1 > 4'd9 || cur_m0 > 4'd9 || m_nx == 8'h00 || m_nx > 8'h12) m_nx = 8'h01;
                d_nx = {cur_d1, cur_d0};
                if (cur_d1 > 4'd9 || cur_d0 > 4'd9 || d_nx == 8'h00) d_nx = 8'h01;
                state_nx = EDIT_Y;
            end
            EDIT_Y: if (mode_p) begin
                d_nx     = (set_d > md) ? md : set_d;
                state_nx = EDIT_M;
            end else if (inc_p) begin
                y_nx = (set_y == 8'h99) ? 8'h00 : bcd_inc(set_y);
            end
            EDIT_M: if (mode_p) begin
                d_nx     = (set_d > md) ? md : set_d;
                state_nx = EDIT_D;
            end else if (inc_p) begin
                m_nx = (set_m >= 8'h12) ? 8'h01 : bcd_inc(set_m);
            end
            EDIT_D: if (mode_p) begin
                state_nx = COMMIT;
            end else if (inc_p) begin
                d_nx = (set_d >= md) ? 8'h01 : bcd_inc(set_d);
            end
            COMMIT:  state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign edit_nx = (state_nx == EDIT_Y) || (state_nx == EDIT_M) || (state_nx == EDIT_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            set_y     <= 8'h00;
            set_m     <= 8'h01;
            set_d     <= 8'h01;
            load      <= 1'b0;
            editing   <= 1'b0;
            field_sel <= 2'd0;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            state   <= state_nx;
            set_y   <= y_nx;
            set_m   <= m_nx;
            set_d   <= d_nx;
            load    <= (state_nx == COMMIT);
            editing <= edit_nx;
            case (state_nx)
                EDIT_Y:  field_sel <= 2'd1;
                EDIT_M:  field_sel <= 2'd2;
                EDIT_D:  field_sel <= 2'd3;
                default: field_sel <= 2'd0;
            endcase
            if (!edit_nx) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign {set_y1, set_y0} = set_y;
    assign {set_m1, set_m0} = set_m;
    assign {set_d1, set_d0} = set_d;

endmodule

// File: tb/tb_date_preset_ctrl.sv
// Randomized bench for date_preset_ctrl: calendar model predicts each committed date and the edit state.
module tb_date_preset_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0;
    logic [3:0] cur_y1 = '0, cur_y0 = '0, cur_m1 = '0, cur_m0 = '0, cur_d1 = '0, cur_d0 = '0;
    logic [3:0] set_y1, set_y0, set_m1, set_m0, set_d1, set_d0;
    logic       load, editing, blink;
    logic [1:0] field_sel;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] exp_q[$];
    logic load_prev = 1'b0;

    // Reference model: plain integer calendar fields plus edit step 0=run 1=year 2=month 3=day.
    int st = 0, my = 0, mm = 1, md = 1;
    int cy = 0, cm = 1, cd = 1;

    always #5 clk = ~clk;

    date_preset_ctrl #(.DEB_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_y1(cur_y1), .cur_y0(cur_y0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .cur_d1(cur_d1), .cur_d0(cur_d0),
        .set_y1(set_y1), .set_y0(set_y0), .set_m1(set_m1), .set_m0(set_m0),
        .set_d1(set_d1), .set_d0(set_d0),
        .load(load), .editing(editing), .field_sel(field_sel), .blink(blink)
    );

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int days_in(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_mode();
        case (st)
            0: begin
                my = cy;
                mm = (cm == 0 || cm > 12) ? 1 : cm;
                md = (cd == 0) ? 1 : cd;
                st = 1;
            end
            1, 2: begin
                if (md > days_in(mm, my)) md = days_in(mm, my);
                st = st + 1;
            end
            default: begin
                exp_q.push_back({bcd(my), bcd(mm), bcd(md)});
                st = 0;
            end
        endcase
    endtask

    task automatic model_inc();
        case (st)
            1: my = (my + 1) % 100;
            2: mm = (mm % 12) + 1;
            3: md = (md >= days_in(mm, my)) ? 1 : md + 1;
            default: ;
        endcase
    endtask

    task automatic set_cur(input int y, input int m, input int d);
        cy = y; cm = m; cd = d;
        cur_y1 = 4'(y / 10); cur_y0 = 4'(y % 10);
        cur_m1 = 4'(m / 10); cur_m0 = 4'(m % 10);
        cur_d1 = 4'(d / 10); cur_d0 = 4'(d % 10);
    endtask

    task automatic press(input bit pm, input bit pi);
        if (pm) model_mode();
        else if (pi) model_inc();
        @(posedge clk); #1;
        btn_mode = pm; btn_inc = pi;
        repeat (10) @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_field_sel"}, int'(field_sel), st);
        chk({tag, "_editing"}, int'(editing), int'(st != 0));
        chk({tag, "_set_date"}, int'({set_y1, set_y0, set_m1, set_m0, set_d1, set_d0}),
            int'({bcd(my), bcd(mm), bcd(md)}));
    endtask

    // Monitor: every load pulse is matched against the oldest predicted commit.
    always @(negedge clk) begin
        if (rst && load) begin
            chk("load_width", int'(load_prev), 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_load: got load=1 required no load at %0t", $time);
            end else begin
                chk("load_date", int'({set_y1, set_y0, set_m1, set_m0, set_d1, set_d0}),
                    int'(exp_q.pop_front()));
                chk("load_field_sel", int'(field_sel), 0);
            end
        end
        load_prev <= load;
    end

    initial begin
        int toggles;
        logic prev_blink;

        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset_blink", int'(blink), 0);
        chk("reset_load", int'(load), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);

        // Plain walk-through with blink observation in the year field.
        set_cur(17, 3, 15);
        press(1, 0); check_state("walk_y");
        toggles = 0;
        @(negedge clk); prev_blink = blink;
        repeat (16) begin
            @(negedge clk);
            if (blink != prev_blink) toggles++;
            prev_blink = blink;
        end
        chk("blink_toggles", toggles, 2);
        repeat (3) begin press(1, 0); check_state("walk"); end
        chk("walk_blink_run", int'(blink), 0);

        // Wrap boundaries on every field.
        set_cur(99, 12, 31);
        press(1, 0); press(0, 1); check_state("wrap_y");
        press(1, 0); press(0, 1); check_state("wrap_m");
        press(1, 0); press(0, 1); check_state("wrap_d");
        press(1, 0); check_state("wrap_commit");

        // February clamp on leaving month edit, leap and non-leap.
        for (int y = 16; y <= 17; y++) begin
            set_cur(y, 1, 31);
            press(1, 0); press(1, 0); press(0, 1); press(1, 0);
            check_state("feb_clamp");
            chk("feb_day", int'({set_d1, set_d0}), (y == 16) ? 8'h29 : 8'h28);
            press(1, 0);
        end

        // Short bounces must not register; the long hold gives one increment.
        set_cur(5, 6, 7);
        press(1, 0);
        repeat (4) begin
            @(posedge clk); #1 btn_inc = 1'b1;
            repeat (3) @(posedge clk);
            #1 btn_inc = 1'b0;
            repeat (2) @(posedge clk);
        end
        model_inc();
        @(posedge clk); #1 btn_inc = 1'b1;
        repeat (20) @(posedge clk);
        #1 btn_inc = 1'b0;
        repeat (20) @(posedge clk);
        check_state("bounce");
        repeat (3) press(1, 0);
        check_state("bounce_commit");

        // Mode and increment on the same cycle: mode wins.
        set_cur(5, 6, 7);
        press(1, 0);
        press(1, 1); check_state("simul");
        press(1, 0); press(1, 0); check_state("simul_commit");

        // Random sessions.
        for (int it = 0; it < 8; it++) begin
            set_cur($urandom_range(0, 99), $urandom_range(0, 15), $urandom_range(0, 31));
            for (int f = 0; f < 3; f++) begin
                press(1, 0); check_state("rand_enter");
                repeat ($urandom_range(0, 12)) press(0, 1);
                check_state("rand_inc");
            end
            press(1, 0); check_state("rand_commit");
        end

        // Reset during day edit discards everything.
        set_cur(20, 6, 30);
        press(1, 0); press(1, 0); press(1, 0); check_state("pre_reset");
        @(posedge clk); #3 rst = 1'b0;
        st = 0; my = 0; mm = 1; md = 1;
        repeat (2) @(posedge clk);
        check_state("in_reset");
        chk("in_reset_blink", int'(blink), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        check_state("post_reset");
        chk("post_reset_blink", int'(blink), 0);

        chk("pending_loads", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
